// File: rtl/ex_ctrl_pkg.sv
// Shared types and constants for the execute-stage sequencing logic.
package ex_ctrl_pkg;

   localparam int REG_ADDR_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_REDIR   = 2'd1,
      ST_MC_BUSY = 2'd2
   } state_t;

   localparam logic [1:0] WB_SRC_MEM = 2'd1;

endpackage

// File: rtl/ex_load_use_detect.sv
// Load-use hazard detect: EX load result needed by the instruction in ID.
module ex_load_use_detect
   import ex_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  i_ex_valid,
   input  logic                  i_ex_is_load,
   input  logic                  i_ex_rf_wb,
   input  logic [REG_ADDR_W-1:0] i_ex_rd,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   input  logic                  i_id_uses_rs1,
   input  logic                  i_id_uses_rs2,
   output logic                  o_lu
);

   logic w_ex_ld;
   logic w_hit1;
   logic w_hit2;

   // x0 is hardwired zero, so a load targeting it never produces a hazard
   assign w_ex_ld = i_ex_valid & i_ex_is_load & i_ex_rf_wb & (i_ex_rd != '0);
   assign w_hit1  = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
   assign w_hit2  = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
   assign o_lu    = w_ex_ld & i_id_valid & (w_hit1 | w_hit2);

endmodule

// File: rtl/ex_pipeline_ctrl.sv
// Execute-stage sequencing: stalls, flushes, redirects and multi-cycle handshake.
module ex_pipeline_ctrl
   import ex_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  id_is_mc,
   input  logic                  ex_valid,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_rf_wb,
   input  logic                  ex_is_load,
   input  logic                  ex_branch_taken,
   input  logic                  ex_is_jump,
   input  logic                  mc_done,
   output logic                  stall_if,
   output logic                  stall_id,
   output logic                  flush_id,
   output logic                  bubble_ex,
   output logic                  pc_redirect,
   output logic                  mc_start,
   output logic                  mc_error,
   output logic [CNT_W-1:0]      stall_count,
   output logic [1:0]            state
);

   localparam int WAIT_W = $clog2(MC_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_wait;
   logic              r_err;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_redir;
   logic              w_lu;
   logic              w_timeout;
   logic              w_wait_clr;

   assign w_redir = ex_valid & (ex_branch_taken | ex_is_jump);

   ex_load_use_detect #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_lu (
      .i_ex_valid   (ex_valid),
      .i_ex_is_load (ex_is_load),
      .i_ex_rf_wb   (ex_rf_wb),
      .i_ex_rd      (ex_rd),
      .i_id_valid   (id_valid),
      .i_id_rs1     (id_rs1),
      .i_id_rs2     (id_rs2),
      .i_id_uses_rs1(id_uses_rs1),
      .i_id_uses_rs2(id_uses_rs2),
      .o_lu         (w_lu)
   );

   always_comb begin
      w_next      = r_state;
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      flush_id    = 1'b0;
      bubble_ex   = 1'b0;
      pc_redirect = 1'b0;
      mc_start    = 1'b0;
      w_timeout   = 1'b0;
      w_wait_clr  = 1'b0;
      if (!rst) begin
         unique case (r_state)
            ST_RUN: begin
               if (w_redir) begin
                  pc_redirect = 1'b1;
                  flush_id    = 1'b1;
                  bubble_ex   = 1'b1;
                  w_next      = ST_REDIR;
               end else if (w_lu) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  bubble_ex = 1'b1;
               end else if (id_valid && id_is_mc) begin
                  mc_start   = 1'b1;
                  stall_if   = 1'b1;
                  stall_id   = 1'b1;
                  bubble_ex  = 1'b1;
                  w_wait_clr = 1'b1;
                  w_next     = ST_MC_BUSY;
               end
            end
            // squash the wrong-path fetch that was already in flight
            ST_REDIR: begin
               flush_id  = 1'b1;
               bubble_ex = 1'b1;
               w_next    = ST_RUN;
            end
            ST_MC_BUSY: begin
               if (mc_done) begin
                  w_next = ST_RUN;
               end else if (r_wait == WAIT_LAST) begin
                  w_timeout = 1'b1;
                  w_next    = ST_RUN;
               end else begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  bubble_ex = 1'b1;
               end
            end
            default: w_next = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_wait  <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_wait_clr) begin
            r_wait <= '0;
         end else if (r_state == ST_MC_BUSY) begin
            r_wait <= r_wait + 1'b1;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
         if (stall_id && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign mc_error    = r_err;
   assign stall_count = r_cnt;
   assign state       = r_state;

endmodule

// File: tb/tb_ex_pipeline_ctrl.sv
// Self-checking bench for ex_pipeline_ctrl against a cycle-level reference model.
module tb_ex_pipeline_ctrl;

   localparam int RW   = 5;
   localparam int TO   = 8;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid, id_uses_rs1, id_uses_rs2, id_is_mc;
   logic [RW-1:0] id_rs1, id_rs2, ex_rd;
   logic          ex_valid, ex_rf_wb, ex_is_load, ex_branch_taken, ex_is_jump;
   logic          mc_done;
   logic          stall_if, stall_id, flush_id, bubble_ex, pc_redirect, mc_start;
   logic          mc_error;
   logic [CW-1:0] stall_count;
   logic [1:0]    state;

   ex_pipeline_ctrl #(.REG_ADDR_W(RW), .MC_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_mc(id_is_mc),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rf_wb(ex_rf_wb),
      .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
      .ex_is_jump(ex_is_jump), .mc_done(mc_done),
      .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
      .bubble_ex(bubble_ex), .pc_redirect(pc_redirect), .mc_start(mc_start),
      .mc_error(mc_error), .stall_count(stall_count), .state(state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst === 1'b0)
         assert (!(state == 2'd2 && ex_valid === 1'b1))
            else $error("FAIL ex_valid_in_mc_busy: ex_valid=1 while busy");
   end

   // model: pending squash cycle, index of current busy cycle (0 = idle)
   bit  m_sq;
   int  m_k;
   bit  m_err;
   int  m_cnt;

   int  n_cmp = 0;
   int  n_bad = 0;
   logic [8:0]    act_v, exp_v;
   logic [CW-1:0] act_cnt, exp_cnt;

   task automatic idle();
      id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_is_mc = 0;
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      ex_valid = 0; ex_rf_wb = 0; ex_is_load = 0;
      ex_branch_taken = 0; ex_is_jump = 0; mc_done = 0;
   endtask

   task automatic set_lu(input logic [RW-1:0] rd, input logic [RW-1:0] rs2);
      ex_valid = 1; ex_is_load = 1; ex_rf_wb = 1; ex_rd = rd;
      id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5'd3;
      id_uses_rs2 = 1; id_rs2 = rs2;
   endtask

   // sample DUT mid-cycle, compute expectation, then advance one clock
   task automatic tick();
      bit st, fl, bu, rd_o, sr, redir, lu, n_sq, n_e;
      int n_k;
      logic [1:0] e_state;
      #4;
      act_v   = {stall_if, stall_id, flush_id, bubble_ex, pc_redirect,
                 mc_start, state, mc_error};
      act_cnt = stall_count;
      st = 0; fl = 0; bu = 0; rd_o = 0; sr = 0; n_e = 0;
      n_sq = 0; n_k = m_k;
      e_state = m_sq ? 2'd1 : (m_k > 0 ? 2'd2 : 2'd0);
      if (!rst) begin
         redir = ex_valid && (ex_branch_taken || ex_is_jump);
         lu = ex_valid && ex_is_load && ex_rf_wb && ex_rd != 0 && id_valid &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
         if (m_sq) begin
            fl = 1; bu = 1;
         end else if (m_k > 0) begin
            if (mc_done || m_k == TO) begin
               n_e = !mc_done; n_k = 0;
            end else begin
               st = 1; bu = 1; n_k = m_k + 1;
            end
         end else if (redir) begin
            rd_o = 1; fl = 1; bu = 1; n_sq = 1;
         end else if (lu) begin
            st = 1; bu = 1;
         end else if (id_valid && id_is_mc) begin
            sr = 1; st = 1; bu = 1; n_k = 1;
         end
      end
      exp_v   = {st, st, fl, bu, rd_o, sr, e_state, m_err};
      exp_cnt = CW'(m_cnt);
      @(posedge clk);
      if (rst) begin
         m_sq = 0; m_k = 0; m_err = 0; m_cnt = 0;
      end else begin
         m_sq = n_sq; m_k = n_k; m_err = m_err | n_e;
         if (st && m_cnt < CMAX) m_cnt++;
      end
      #1;
   endtask

   task automatic do_reset();
      idle(); rst = 1; tick(); tick(); rst = 0;
   endtask

   task automatic test_reset();
      idle(); rst = 1;
      id_valid = 1; id_is_mc = 1; ex_valid = 1; ex_branch_taken = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (act_v[8:3] !== 6'b0) begin
            n_bad++; $display("FAIL reset_outs: got %b want 000000", act_v[8:3]);
         end
      end
      rst = 0; idle(); tick();
      n_cmp++;
      if (act_v !== exp_v || act_cnt !== exp_cnt) begin
         n_bad++; $display("FAIL reset_state: got %b/%0d want %b/%0d",
                           act_v, act_cnt, exp_v, exp_cnt);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      set_lu(5'd5, 5'd5); tick();
      n_cmp++;
      if (act_v !== exp_v || act_v !== 9'b110100000) begin
         n_bad++; $display("FAIL lu_hit: got %b want %b", act_v, exp_v);
      end
      idle(); tick();
      n_cmp++;
      if (act_v !== exp_v || act_cnt !== 4'd1) begin
         n_bad++; $display("FAIL lu_after: got %b/%0d want %b/1", act_v, act_cnt, exp_v);
      end
   endtask

   task automatic test_x0();
      do_reset();
      set_lu(5'd0, 5'd7); id_rs1 = 5'd0; tick();
      n_cmp++;
      if (act_v !== exp_v || act_v[8:3] !== 6'b0) begin
         n_bad++; $display("FAIL lu_x0: got %b want %b", act_v, exp_v);
      end
   endtask

   task automatic test_redir_priority();
      do_reset();
      set_lu(5'd5, 5'd5); ex_branch_taken = 1; tick();
      n_cmp++;
      if (act_v !== exp_v || act_v[8:3] !== 6'b001110) begin
         n_bad++; $display("FAIL redir_c0: got %b want %b", act_v, exp_v);
      end
      tick();
      n_cmp++;
      if (act_v !== exp_v || act_v[8:1] !== 8'b00110001) begin
         n_bad++; $display("FAIL redir_c1: got %b want %b", act_v, exp_v);
      end
      idle(); tick();
      n_cmp++;
      if (act_v !== exp_v || act_v[2:1] !== 2'd0) begin
         n_bad++; $display("FAIL redir_c2: got %b want %b", act_v, exp_v);
      end
   endtask

   task automatic test_mc_done(input int d);
      int hi;
      do_reset();
      id_valid = 1; id_is_mc = 1; tick();
      hi = int'(act_v[7]);
      n_cmp++;
      if (act_v !== exp_v || act_v[3] !== 1'b1) begin
         n_bad++; $display("FAIL mc_start_%0d: got %b want %b", d, act_v, exp_v);
      end
      idle();
      for (int k = 1; k <= d; k++) begin
         mc_done = (k == d); tick();
         hi += int'(act_v[7]);
         n_cmp++;
         if (act_v !== exp_v) begin
            n_bad++; $display("FAIL mc_busy_%0d_k%0d: got %b want %b", d, k, act_v, exp_v);
         end
      end
      idle(); tick();
      n_cmp++;
      if (act_v !== exp_v || hi != d || act_cnt !== CW'(d) || act_v[0] !== 1'b0) begin
         n_bad++; $display("FAIL mc_done_%0d: got hi=%0d cnt=%0d v=%b want hi=%0d cnt=%0d v=%b",
                           d, hi, act_cnt, act_v, d, d, exp_v);
      end
   endtask

   task automatic test_mc_timeout();
      int rel;
      do_reset();
      rel = -1;
      id_valid = 1; id_is_mc = 1; tick(); idle();
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (rel < 0 && act_v[7] === 1'b0) rel = k;
         n_cmp++;
         if (act_v !== exp_v) begin
            n_bad++; $display("FAIL to_k%0d: got %b want %b", k, act_v, exp_v);
         end
      end
      n_cmp++;
      if (rel != TO || act_v[0] !== 1'b1) begin
         n_bad++; $display("FAIL to_release: got k=%0d err=%b want k=%0d err=1",
                           rel, act_v[0], TO);
      end
      set_lu(5'd9, 5'd9); tick(); idle(); tick();
      n_cmp++;
      if (act_v !== exp_v || act_v[0] !== 1'b1) begin
         n_bad++; $display("FAIL to_sticky: got %b want %b", act_v, exp_v);
      end
      do_reset(); tick();
      n_cmp++;
      if (act_v[0] !== 1'b0) begin
         n_bad++; $display("FAIL to_clear: got %b want 0", act_v[0]);
      end
   endtask

   task automatic test_reset_mid_mc();
      do_reset();
      id_valid = 1; id_is_mc = 1; tick(); idle();
      repeat (3) tick();
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (act_v[8:3] !== 6'b0) begin
            n_bad++; $display("FAIL rmid_outs: got %b want 000000", act_v[8:3]);
         end
      end
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (act_v !== exp_v || act_cnt !== 4'd0 || act_v[3] !== 1'b0) begin
            n_bad++; $display("FAIL rmid_after%0d: got %b/%0d want %b/0", i, act_v, act_cnt, exp_v);
         end
      end
   endtask

   task automatic test_saturate();
      do_reset();
      set_lu(5'd4, 5'd4);
      repeat (CMAX + 5) tick();
      idle(); tick();
      n_cmp++;
      if (act_cnt !== CW'(CMAX)) begin
         n_bad++; $display("FAIL saturate: got %0d want %0d", act_cnt, CMAX);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst             = ($urandom_range(0, 149) == 0);
         ex_valid        = (m_k > 0) ? 1'b0 : 1'($urandom);
         ex_rd           = RW'($urandom_range(0, 3));
         ex_rf_wb        = ($urandom_range(0, 3) != 0);
         ex_is_load      = 1'($urandom);
         ex_branch_taken = ($urandom_range(0, 5) == 0);
         ex_is_jump      = ($urandom_range(0, 9) == 0);
         id_valid        = ($urandom_range(0, 3) != 0);
         id_rs1          = RW'($urandom_range(0, 3));
         id_rs2          = RW'($urandom_range(0, 3));
         id_uses_rs1     = 1'($urandom);
         id_uses_rs2     = 1'($urandom);
         id_is_mc        = ($urandom_range(0, 5) == 0);
         mc_done         = ($urandom_range(0, 6) == 0);
         tick();
         n_cmp++;
         if (act_v !== exp_v || act_cnt !== exp_cnt) begin
            n_bad++; $display("FAIL rand_%0d: got %b/%0d want %b/%0d",
                              i, act_v, act_cnt, exp_v, exp_cnt);
         end
      end
   endtask

   initial begin
      m_sq = 0; m_k = 0; m_err = 0; m_cnt = 0;
      idle(); rst = 1;
      @(posedge clk); #1;
      test_reset();
      test_load_use();
      test_x0();
      test_redir_priority();
      test_mc_done(6);
      test_mc_done(1);
      test_mc_done(3);
      test_mc_done(TO);
      test_mc_timeout();
      test_reset_mid_mc();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
